// File: rtl/vote_poller_if.sv
// Handshake bundle between the vote poller and its environment.
// The slave modport is the poller itself; the master side drives start and the voter responses.
interface vote_poller_if;
    logic       start;
    logic [3:0] req;
    logic       ack;
    logic       vote;
    logic [3:0] I;
    logic [3:0] abstain;
    logic       busy;
    logic       done;

    modport master (
        output start, ack, vote,
        input  req, I, abstain, busy, done
    );

    modport slave (
        input  start, ack, vote,
        output req, I, abstain, busy, done
    );
endinterface

// File: rtl/vote_poller.sv
// Polls four voters in turn and publishes the assembled ballot once all have answered.
// Define VOTE_TIMEOUT_EN to abandon a silent voter after TIMEOUT_CYC unanswered cycles.
module vote_poller #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    vote_poller_if.slave  bus
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] shadowVote_q, shadowVote_d;
    logic [3:0] ballot_q, ballot_d;
    logic       advance;

`ifdef VOTE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    logic [7:0] cnt_q, cnt_d;
    logic [3:0] shadowAbst_q, shadowAbst_d;
    logic [3:0] abstain_q, abstain_d;
    logic       timedOut;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            shadowVote_q <= 4'd0;
            ballot_q     <= 4'd0;
`ifdef VOTE_TIMEOUT_EN
            cnt_q        <= 8'd0;
            shadowAbst_q <= 4'd0;
            abstain_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadowVote_q <= shadowVote_d;
            ballot_q     <= ballot_d;
`ifdef VOTE_TIMEOUT_EN
            cnt_q        <= cnt_d;
            shadowAbst_q <= shadowAbst_d;
            abstain_q    <= abstain_d;
`endif
        end
    end

    // The published ballot is taken from the next-state shadow so the final voter's answer lands together with done.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadowVote_d = shadowVote_q;
        ballot_d     = ballot_q;
        advance      = 1'b0;
`ifdef VOTE_TIMEOUT_EN
        cnt_d        = cnt_q;
        shadowAbst_d = shadowAbst_q;
        abstain_d    = abstain_q;
        timedOut     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = POLL;
                    idx_d        = 2'd0;
                    shadowVote_d = 4'd0;
`ifdef VOTE_TIMEOUT_EN
                    shadowAbst_d = 4'd0;
                    cnt_d        = 8'd0;
`endif
                end
            end

            POLL: begin
`ifdef VOTE_TIMEOUT_EN
                timedOut = (cnt_q == TIMEOUT_LIM) && !bus.ack;
`endif
                if (bus.ack) begin
                    shadowVote_d[idx_q] = bus.vote;
`ifdef VOTE_TIMEOUT_EN
                    shadowAbst_d[idx_q] = 1'b0;
`endif
                    advance = 1'b1;
                end
`ifdef VOTE_TIMEOUT_EN
                else if (timedOut) begin
                    shadowVote_d[idx_q] = 1'b0;
                    shadowAbst_d[idx_q] = 1'b1;
                    advance = 1'b1;
                end
                cnt_d = advance ? 8'd0 : cnt_q + 8'd1;
`endif
                if (advance) begin
                    if (idx_q == 2'd3) begin
                        state_d   = DONE;
                        idx_d     = 2'd0;
                        ballot_d  = shadowVote_d;
`ifdef VOTE_TIMEOUT_EN
                        abstain_d = shadowAbst_d;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req  = (state_q == POLL) ? (4'b0001 << idx_q) : 4'b0000;
    assign bus.busy = (state_q == POLL);
    assign bus.done = (state_q == DONE);
    assign bus.I    = ballot_q;

`ifdef VOTE_TIMEOUT_EN
    assign bus.abstain = abstain_q;
`else
    assign bus.abstain = 4'b0000;
`endif

endmodule

// File: tb/tb_vote_poller.sv
// Self-checking bench for vote_poller: a responder model drives the voters and a
// scoreboard queue holds the ballot, abstain mask and done cycle expected per session.
module tb_vote_poller;

    localparam int TO = 8;
`ifdef VOTE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vote_poller_if bus ();

    vote_poller #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] ballot;
        logic [3:0] abst;
        int         doneCyc;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    int         dly[4];
    logic [3:0] votes;
    bit         strayStart;
    bit         holdStart;

    // One polling session: cycle 0 is the cycle start is driven; voter v acks after dly[v] waiting cycles.
    task automatic run_session(input string name);
        exp_t       e;
        exp_t       got;
        int         idx;
        int         waitCnt;
        int         cyc;
        int         total;
        logic [3:0] expReq;
        bit         ackNow;

        e.ballot = 4'd0;
        e.abst   = 4'd0;
        total    = 0;
        for (int v = 0; v < 4; v++) begin
            if (TO_EN && dly[v] > TO) begin
                e.abst[v] = 1'b1;
                total += TO + 1;
            end else begin
                e.ballot[v] = votes[v];
                total += dly[v] + 1;
            end
        end
        e.doneCyc = total + 1;
        sb.push_back(e);

        checks++;
        if (bus.busy !== 1'b0 || bus.req !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL %s idle_before_start: busy=%b req=%b required busy=0 req=0000", name, bus.busy, bus.req);
        end

        bus.start = 1'b1;
        bus.ack   = 1'b0;
        bus.vote  = 1'b0;
        idx       = 0;
        waitCnt   = 0;
        cyc       = 0;

        while (idx < 4 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            bus.start = strayStart && cyc[0];
            expReq = 4'b0001 << idx;
            checks++;
            if (bus.req !== expReq || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s poll_cycle%0d: req=%b busy=%b done=%b required req=%b busy=1 done=0",
                         name, cyc, bus.req, bus.busy, bus.done, expReq);
            end
            ackNow   = (waitCnt >= dly[idx]);
            bus.ack  = ackNow;
            bus.vote = ackNow ? votes[idx] : 1'($urandom);
            if (ackNow || (TO_EN && waitCnt == TO)) begin
                idx++;
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end

        checks++;
        if (idx < 4) begin
            failures++;
            $display("[TB] FAIL %s poll_bound: reached voter %0d required 4", name, idx);
        end

        @(negedge clk);
        cyc++;
        bus.ack   = 1'b0;
        bus.start = holdStart;
        for (int k = 0; k < 20 && bus.done !== 1'b1; k++) begin
            @(negedge clk);
            cyc++;
            bus.start = holdStart;
        end

        got = sb.pop_front();
        checks++;
        if (bus.done !== 1'b1 || cyc != got.doneCyc) begin
            failures++;
            $display("[TB] FAIL %s done_cycle: done=%b at cycle %0d required done=1 at cycle %0d",
                     name, bus.done, cyc, got.doneCyc);
        end
        checks++;
        if (bus.I !== got.ballot || bus.abstain !== got.abst) begin
            failures++;
            $display("[TB] FAIL %s ballot: I=%b abstain=%b required I=%b abstain=%b",
                     name, bus.I, bus.abstain, got.ballot, got.abst);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.req !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL %s done_outputs: busy=%b req=%b required busy=0 req=0000", name, bus.busy, bus.req);
        end

        @(negedge clk);
        bus.start = holdStart;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.I !== got.ballot || bus.abstain !== got.abst) begin
            failures++;
            $display("[TB] FAIL %s after_done: done=%b busy=%b I=%b abstain=%b required done=0 busy=0 I=%b abstain=%b",
                     name, bus.done, bus.busy, bus.I, bus.abstain, got.ballot, got.abst);
        end
    endtask

    task automatic set_zero_wait(input logic [3:0] v);
        for (int i = 0; i < 4; i++) dly[i] = 0;
        votes      = v;
        strayStart = 1'b0;
        holdStart  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        bus.vote  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req !== 4'b0000 || bus.I !== 4'b0000 || bus.abstain !== 4'b0000 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: req=%b I=%b abstain=%b busy=%b done=%b required all zero",
                     bus.req, bus.I, bus.abstain, bus.busy, bus.done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_zero_wait(4'b1101);
        run_session("basic");
    endtask

    task automatic test_slow_voter();
        set_zero_wait(4'b0111);
        dly[2] = 3;
        run_session("slow_voter2");
    endtask

    task automatic test_stray();
        logic [3:0] prevI;
        set_zero_wait(4'b1010);
        dly[1]     = 2;
        strayStart = 1'b1;
        run_session("stray_start");
        strayStart = 1'b0;
        prevI      = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            bus.start = 1'b0;
            bus.ack   = 1'b1;
            bus.vote  = k[0];
            @(negedge clk);
            checks++;
            if (bus.I !== prevI || bus.req !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_stray_ack: I=%b req=%b busy=%b done=%b required I=%b req=0000 busy=0 done=0",
                         bus.I, bus.req, bus.busy, bus.done, prevI);
            end
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_zero_wait(4'b0011);
        holdStart = 1'b1;
        run_session("b2b_first");
        holdStart = 1'b0;
        votes     = 4'b1100;
        dly[3]    = 1;
        run_session("b2b_second");
    endtask

`ifdef VOTE_TIMEOUT_EN
    task automatic test_timeout();
        set_zero_wait(4'b1111);
        dly[1] = 1000;
        run_session("timeout_silent");
        dly[1] = TO - 1;
        run_session("timeout_ack_last_cycle");
        dly[1] = TO;
        run_session("timeout_ack_on_expiry");
    endtask
`endif

    task automatic test_reset_mid();
        set_zero_wait(4'b1111);
        bus.start = 1'b1;
        bus.ack   = 1'b1;
        bus.vote  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        bus.ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (bus.req !== 4'b0000 || bus.busy !== 1'b0 || bus.I !== 4'b0000 ||
            bus.abstain !== 4'b0000 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: req=%b busy=%b I=%b abstain=%b done=%b required all zero",
                     bus.req, bus.busy, bus.I, bus.abstain, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.I !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL post_reset_idle: done=%b busy=%b I=%b required done=0 busy=0 I=0000",
                         bus.done, bus.busy, bus.I);
            end
        end
        set_zero_wait(4'b0110);
        run_session("fresh_after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_voter();
        test_stray();
        test_back_to_back();
`ifdef VOTE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vote_poller.md
VOTE_POLLER -- requirements
Module: vote_poller

Interface
REQ-001 Parameter: TIMEOUT_CYC, 8, number of cycles a voter request may remain unanswered before it is abandon (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  begin a polling session; sampled only in IDLE.
REQ-005 Port: req  output  4  one-hot request to voter 0..3; all zero when not polling.
REQ-006 Port: ack  input  1  the addressed voter has its vote on "vote" this cycle.
REQ-007 Port: vote  input  1  vote value of the addressed voter, valid only when ack=1.
REQ-008 Port: I  output  4  assembled ballot (bit n = voter n); drives the 4-bit input of the voter block.
REQ-009 Port: abstain  output  4  bit n set when voter n timed out in the last session.
REQ-010 Port: busy  output  1  high from the cycle after start is accepted through the final ack.
REQ-011 Port: done  output  1  one-cycle pulse when I/abstain are updated.

Function
REQ-012 The FSM SHALL have states IDLE, POLL, DONE; IDLE->POLL on start=1; POLL->DONE on the ack (or timeout) of voter 3; DONE->IDLE unconditionally after one cycle.
REQ-013 The block SHALL hold an index idx (0..3); on entry to POLL idx=0 and req=4'b0001 in the first POLL cycle.
REQ-014 The block SHALL assert req[idx] continuously until ack=1 is sampled; vote is then stored in shadow bit idx, and req moves to idx+1 on the next cycle (no bubble).
REQ-015 Minimum latency: start at cycle 0, ack held high -> req0 at cycle 1, acks at cycles 1..4, done=1 at cycle 5.
REQ-016 I and abstain SHALL change only in the DONE cycle, both loaded from the shadow registers at once; they hold their values between sessions.
REQ-017 done SHALL be high exactly in the DONE cycle; busy SHALL be low in IDLE and DONE.
REQ-018 start while in POLL or DONE SHALL be ignored; start held high through DONE starts a new session from IDLE on the following cycle.
REQ-019 ack in IDLE or DONE SHALL be ignored and SHALL NOT alter any register.
REQ-020 The shadow vote and shadow abstain registers SHALL clear to 0 when a session is accepted.

Reset
REQ-021 While rst_n=0: state=IDLE, idx=0, req=0, I=0, abstain=0, busy=0, done=0, timeout counter=0, shadow registers=0.
REQ-022 Reset asserted mid-session SHALL abort it immediately with no done pulse; I keeps no partial ballot (I=0).
REQ-023 The first rising edge after rst_n rises SHALL evaluate IDLE normally (start accepted on that edge).

Configuration
REQ-024 Macro VOTE_TIMEOUT_EN: when defined, a counter SHALL count POLL cycles for the current voter; after TIMEOUT_CYC cycles with no ack, shadow vote bit=0, shadow abstain bit=1, and polling advances exactly as on an ack.
REQ-025 With VOTE_TIMEOUT_EN defined, the counter SHALL restart at 0 on every voter change; an ack in the same cycle the count expires SHALL win (vote recorded, abstain=0).
REQ-026 Without VOTE_TIMEOUT_EN, no counter SHALL be built, the block waits indefinitely for ack, and abstain SHALL be constant 0.

Verification
REQ-027 Reset, start=1 one cycle, ack=1 constantly, vote sequence 1,0,1,1 -> req 0001,0010,0100,1000 on cycles 1..4, done at cycle 5, I=4'b1101, abstain=0.
REQ-028 Voter 2 delays ack by 3 cycles, votes 1,1,1,0 -> req[2] high 4 cycles, done at cycle 8, I=4'b0111.
REQ-029 VOTE_TIMEOUT_EN, TIMEOUT_CYC=8, voter 1 never acks, others vote 1 -> I=4'b1101, abstain=4'b0010, done 8 cycles later than the zero-wait case; voter 1 acks in the 8th cycle -> abstain=0.
REQ-030 Pulse start and ack during POLL/IDLE stray -> start ignored while busy, stray ack in IDLE leaves I unchanged.
REQ-031 rst_n low for one cycle after voter 2 acks -> req=0, busy=0, I=0, no done; a fresh start completes a normal session.
